// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle MULT/DIV unit with HI/LO and start/busy handshake; MDU_MADD_EN adds MADD/MADDU.
module mdu_seq #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXL = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAXL + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic [2:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic acc, is_mul, is_div, done, sgn;
  logic [2*WIDTH-1:0] ea, eb, prod, mul_res;
  logic [WIDTH-1:0] aa, ab, qu, ru, quo, rem;
  assign acc = start && !busy_q;
  assign is_div = op[2:1] == 2'b01;
`ifdef MDU_MADD_EN
  assign is_mul = op[2:1] == 2'b00 || op[2:1] == 2'b11;
  assign mul_res = op_q[2] ? {hi_q, lo_q} + prod : prod;
`else
  assign is_mul = op[2:1] == 2'b00;
  assign mul_res = prod;
`endif
  // Result is computed from the latched operands at the completion edge.
  assign sgn = ~op_q[0];
  assign ea = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
  assign eb = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
  assign prod = ea * eb;
  assign aa = sgn & a_q[WIDTH-1] ? -a_q : a_q;
  assign ab = sgn & b_q[WIDTH-1] ? -b_q : b_q;
  assign qu = ab == '0 ? '0 : aa / ab;
  assign ru = ab == '0 ? '0 : aa % ab;
  assign quo = sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -qu : qu;
  assign rem = sgn & a_q[WIDTH-1] ? -ru : ru;
  assign done = busy_q && cnt_q == CW'(1);
  always_comb begin
    op_d = acc ? op : op_q;
    a_d = acc ? a : a_q;
    b_d = acc ? b : b_q;
    cnt_d = acc ? (is_mul ? CW'(MUL_LAT) : is_div ? CW'(DIV_LAT) : '0) : busy_q ? cnt_q - 1'b1 : cnt_q;
    busy_d = cnt_d != '0;
    hi_d = acc && op == 3'd4 ? a : hi_q;
    lo_d = acc && op == 3'd5 ? a : lo_q;
    if (done && op_q[2:1] != 2'b01) {hi_d, lo_d} = mul_res;
    if (done && op_q[2:1] == 2'b01 && b_q != '0) {hi_d, lo_d} = {rem, quo};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      busy_q <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign busy = busy_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
